pitch_meter: RTL and testbench
==============================

// Module: pitch_meter
// PURPOSE
//  Measures the period of the squared microphone signal and grades it against the selected note.
//  Produces the 5-bit deviation code p for the 4-digit display stage. That stage shows p as -7..-1, 0, +1..+12.
//  Sits directly upstream of the display stage and shares keynote with it; p = 7 + deviation_steps.
// PARAMETERS
//  CLK_HZ      100_000_000   system clock frequency; sets the target-period table
//  CNT_W       21            period counter width; must hold TIMEOUT
//  STEP_SHIFT  5             one deviation step = target >> STEP_SHIFT (~3.1 %)
//  MIN_PERIOD  CLK_HZ/2000   edges closer than this to the last accepted edge are glitches and are ignored
//  TIMEOUT     CLK_HZ/50     no accepted edge for this many cycles means no signal
// PORTS
//  clk        in   1   system clock
//  rst        in   1   synchronous reset, active-high
//  audio_in   in   1   asynchronous squared audio from the comparator
//  keynote    in   10  note request, priority lowest index; 0=L6 1=L7 2..8=M1..M7 9=H1
//  p          out  5   deviation code 0..19; 31 = no signal or no note
//  p_valid    out  1   one-cycle strobe when p is updated
//  signal_ok  out  1   high while edges arrive within TIMEOUT
// BEHAVIOUR
//  - Reset state: p=31, p_valid=0, signal_ok=0, FSM=SYNC, counters=0.
//  - Input conditioning: audio_in passes through a 2-flop synchronizer; a rising edge is detected on the synced signal.
//  - Period counter: increments every cycle and saturates at TIMEOUT.
//  - Accepted edge: an edge with count >= MIN_PERIOD. It latches the period and resets the count to 1.
//  - Glitch edge: an edge with count < MIN_PERIOD leaves the count untouched.
//  - SYNC state: waits for the first accepted edge, then goes to MEASURE. That first period is discarded.
//  - MEASURE state: each accepted edge latches meas = count and goes to COMPARE.
//  - COMPARE, entry: target T = table[note] and step S = T >> STEP_SHIFT.
//    sharp = (meas < T); rem = |T - meas|; k = 0.
//  - COMPARE, iteration: one per cycle; while rem >= S and k < lim, do rem -= S and k++.
//    lim = 12 if sharp, else 7.
//  - COMPARE, exit: p = sharp ? 7+k : 7-k, p_valid=1 for one cycle, return to MEASURE.
//    Latency from edge to p_valid is at most 14 cycles.
//  - Counting during COMPARE: the period counter keeps running. An edge arriving in COMPARE is counted but not graded.
//  - Boundary cases for the result:
//    - meas == T gives p=7.
//    - A deviation beyond the limit clamps to p=0 (flat) or p=19 (sharp).
//    - A remainder below S truncates toward 0.
//  - Timeout: when the count reaches TIMEOUT, set p=31, signal_ok=0, pulse p_valid once, then go to SYNC.
//    signal_ok is set on the first accepted edge after SYNC.
//  - No note: keynote==0 forces p=31 and pulses p_valid once on entry. The FSM holds in SYNC.
//  - Note change: any change of the decoded note aborts COMPARE and goes to SYNC. p holds until the next result.
//  - Reset mid-operation: every register returns to its reset value on the next clk edge.
//  - Simultaneous timeout and edge: the edge wins and the count resets.
// CONFIGURATION
//  PITCH_AVG4_EN defined:
//    - MEASURE sums 4 consecutive accepted periods into a CNT_W+2 accumulator, then sets meas = sum >> 2.
//    - The sum is reset on SYNC or a note change.
//    - p updates every 4th period.
//  PITCH_AVG4_EN undefined: each single period is graded.
// STRUCTURE
//  pitch_pkg holds:
//    - note index localparams (NOTE_L6..NOTE_H1)
//    - note frequencies in centi-Hz: 22000 24694 26163 29366 32963 34923 39200 44000 49388 52325
//    - a constant function period(CLK_HZ, idx) = CLK_HZ*100/f
//    - P_INTUNE=7, P_NONE=31, P_MIN=0, P_MAX=19
//  pitch_period_counter is the one sub-module: synchronizer, edge detect, glitch filter, saturating count, timeout flag.
//    Outputs: edge_ok, period, timeout.
//  FSM, comparator and optional averager stay in pitch_meter.
// TESTING (default parameters: T[7]=227272, S=7102)
//  1. keynote=10'b0010000000, period 227272 for 3 periods -> p_valid pulse from the 2nd period, p=7, signal_ok=1.
//  2. keynote idx7, period 227272-3*7102=205966 -> p=10; period 227272+2*7102+5000=246476 -> p=5.
//  3. keynote idx7, period 100000 -> p=19 (clamp); period 300000 -> p=0 (clamp).
//  4. Edges stop for 2_000_000 cycles -> one p_valid with p=31, signal_ok=0. Restart edges -> first result after 2 periods.
//  5. 10-cycle glitch pulses mid-period -> ignored, p unchanged. keynote->0 -> p=31.
//     Assert rst during COMPARE -> p=31 and p_valid=0 next cycle.
//  6. PITCH_AVG4_EN: periods 220000,230000,230000,229088 -> single update after the 4th, p=7.

Source files
------------

// File: rtl/pitch_pkg.sv
// pitch_pkg: note indices, result codes and the clock-derived target-period helper
// shared by the pitch meter and its period counter.
package pitch_pkg;

  localparam int NUM_NOTES = 10;

  localparam int NOTE_L6 = 0;
  localparam int NOTE_L7 = 1;
  localparam int NOTE_M1 = 2;
  localparam int NOTE_M2 = 3;
  localparam int NOTE_M3 = 4;
  localparam int NOTE_M4 = 5;
  localparam int NOTE_M5 = 6;
  localparam int NOTE_M6 = 7;
  localparam int NOTE_M7 = 8;
  localparam int NOTE_H1 = 9;

  localparam logic [4:0] P_INTUNE = 5'd7;
  localparam logic [4:0] P_NONE   = 5'd31;
  localparam logic [4:0] P_MIN    = 5'd0;
  localparam logic [4:0] P_MAX    = 5'd19;

  typedef enum logic [1:0] {
    ST_SYNC,
    ST_MEASURE,
    ST_COMPARE
  } state_t;

  // Note frequencies in centi-Hz.
  function automatic longint note_freq(int idx);
    case (idx)
      NOTE_L6: return 64'd22000;
      NOTE_L7: return 64'd24694;
      NOTE_M1: return 64'd26163;
      NOTE_M2: return 64'd29366;
      NOTE_M3: return 64'd32963;
      NOTE_M4: return 64'd34923;
      NOTE_M5: return 64'd39200;
      NOTE_M6: return 64'd44000;
      NOTE_M7: return 64'd49388;
      default: return 64'd52325;
    endcase
  endfunction

  // Target period in clock cycles; evaluated only at elaboration time.
  function automatic longint period(longint clk_hz, int idx);
    return (clk_hz * 64'd100) / note_freq(idx);
  endfunction

endpackage

// File: rtl/pitch_period_counter.sv
// pitch_period_counter: synchronizes the comparator output, detects rising edges,
// rejects edges closer than MIN_PERIOD and runs the saturating period count.
module pitch_period_counter #(
  parameter int CNT_W      = 21,
  parameter int MIN_PERIOD = 50_000,
  parameter int TIMEOUT    = 2_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             audio_in,
  output logic             edge_ok,
  output logic [CNT_W-1:0] period,
  output logic             timeout
);

  logic             sync1, sync2, sync_d;
  logic [CNT_W-1:0] count;
  logic             rise;

  assign rise    = sync2 & ~sync_d;
  assign edge_ok = rise && (count >= CNT_W'(MIN_PERIOD));
  assign period  = count;
  // An edge in the same cycle as saturation wins: the count restarts instead.
  assign timeout = (count == CNT_W'(TIMEOUT)) && !edge_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sync_d <= 1'b0;
      count  <= '0;
    end else begin
      sync1  <= audio_in;
      sync2  <= sync1;
      sync_d <= sync2;
      if (edge_ok)
        count <= CNT_W'(1);
      else if (count != CNT_W'(TIMEOUT))
        count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pitch_meter.sv
// pitch_meter: grades the measured audio period against the selected note and emits
// the deviation code p. Define PITCH_AVG4_EN to grade the mean of four accepted periods.
module pitch_meter
  import pitch_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int CNT_W      = 21,
  parameter int STEP_SHIFT = 5,
  parameter int MIN_PERIOD = CLK_HZ / 2000,
  parameter int TIMEOUT    = CLK_HZ / 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       audio_in,
  input  logic [9:0] keynote,
  output logic [4:0] p,
  output logic       p_valid,
  output logic       signal_ok
);

  localparam logic [3:0] LIM_SHARP = 4'(P_MAX - P_INTUNE);
  localparam logic [3:0] LIM_FLAT  = 4'(P_INTUNE - P_MIN);

  logic             edge_ok, timeout;
  logic [CNT_W-1:0] period_cnt;

  pitch_period_counter #(
    .CNT_W      (CNT_W),
    .MIN_PERIOD (MIN_PERIOD),
    .TIMEOUT    (TIMEOUT)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .audio_in (audio_in),
    .edge_ok  (edge_ok),
    .period   (period_cnt),
    .timeout  (timeout)
  );

  logic [CNT_W-1:0] tbl [NUM_NOTES];
  for (genvar g = 0; g < NUM_NOTES; g++) begin : g_tbl
    assign tbl[g] = CNT_W'(period(CLK_HZ, g));
  end

  logic [3:0] note_idx, note_idx_q;
  logic       note_v, note_v_q, note_chg;

  // Lowest set bit wins.
  always_comb begin
    note_idx = '0;
    for (int i = NUM_NOTES - 1; i >= 0; i--)
      if (keynote[i]) note_idx = 4'(i);
  end

  assign note_v   = |keynote;
  assign note_chg = note_v && (!note_v_q || (note_idx != note_idx_q));

  state_t           state, state_n;
  logic [CNT_W-1:0] rem, rem_n, step, step_n;
  logic [3:0]       k, k_n;
  logic             sharp, sharp_n;
  logic [4:0]       p_n;
  logic             pv_n, ok_n;
  logic             load;
  logic [CNT_W-1:0] m, tgt;

`ifdef PITCH_AVG4_EN
  logic [CNT_W+1:0] acc, acc_n, sum;
  logic [1:0]       n4, n4_n;
`endif

  always_comb begin
    state_n = state;
    p_n     = p;
    pv_n    = 1'b0;
    ok_n    = signal_ok;
    rem_n   = rem;
    step_n  = step;
    k_n     = k;
    sharp_n = sharp;
    load    = 1'b0;
    m       = period_cnt;
    tgt     = tbl[note_idx];
`ifdef PITCH_AVG4_EN
    acc_n   = acc;
    n4_n    = n4;
    sum     = acc + (CNT_W+2)'(period_cnt);
`endif
    if (!note_v) begin
      state_n = ST_SYNC;
      if (note_v_q) begin
        p_n  = P_NONE;
        pv_n = 1'b1;
      end
    end else if (note_chg) begin
      state_n = ST_SYNC;
    end else begin
      case (state)
        ST_SYNC: begin
`ifdef PITCH_AVG4_EN
          acc_n = '0;
          n4_n  = '0;
`endif
          // The period ending at this edge started before we were listening.
          if (edge_ok) begin
            state_n = ST_MEASURE;
            ok_n    = 1'b1;
          end
        end
        ST_MEASURE: begin
          if (edge_ok) begin
`ifdef PITCH_AVG4_EN
            if (n4 == 2'd3) begin
              load  = 1'b1;
              m     = sum[CNT_W+1:2];
              acc_n = '0;
              n4_n  = '0;
            end else begin
              acc_n = sum;
              n4_n  = n4 + 2'd1;
            end
`else
            load = 1'b1;
`endif
          end else if (timeout) begin
            state_n = ST_SYNC;
            p_n     = P_NONE;
            pv_n    = 1'b1;
          end
        end
        ST_COMPARE: begin
          if (timeout) begin
            state_n = ST_SYNC;
            p_n     = P_NONE;
            pv_n    = 1'b1;
          end else if (rem >= step && k < (sharp ? LIM_SHARP : LIM_FLAT)) begin
            rem_n = rem - step;
            k_n   = k + 4'd1;
          end else begin
            state_n = ST_MEASURE;
            pv_n    = 1'b1;
            p_n     = sharp ? P_INTUNE + 5'(k) : P_INTUNE - 5'(k);
          end
        end
        default: state_n = ST_SYNC;
      endcase
    end
    // Short period means high pitch: sharp.
    if (load) begin
      state_n = ST_COMPARE;
      step_n  = tgt >> STEP_SHIFT;
      sharp_n = m < tgt;
      rem_n   = (m < tgt) ? tgt - m : m - tgt;
      k_n     = '0;
    end
    if (timeout) ok_n = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_SYNC;
      p          <= P_NONE;
      p_valid    <= 1'b0;
      signal_ok  <= 1'b0;
      rem        <= '0;
      step       <= '0;
      k          <= '0;
      sharp      <= 1'b0;
      note_idx_q <= '0;
      note_v_q   <= 1'b0;
`ifdef PITCH_AVG4_EN
      acc        <= '0;
      n4         <= '0;
`endif
    end else begin
      state      <= state_n;
      p          <= p_n;
      p_valid    <= pv_n;
      signal_ok  <= ok_n;
      rem        <= rem_n;
      step       <= step_n;
      k          <= k_n;
      sharp      <= sharp_n;
      note_idx_q <= note_idx;
      note_v_q   <= note_v;
`ifdef PITCH_AVG4_EN
      acc        <= acc_n;
      n4         <= n4_n;
`endif
    end
  end

endmodule

// File: tb/tb_pitch_meter.sv
// tb_pitch_meter: drives square waves of chosen periods and compares every p_valid
// result against an edge-timing reference model of the meter.
module tb_pitch_meter;

  localparam int CLK_HZ = 500_000;
  localparam int MIN_P  = CLK_HZ / 2000;
  localparam int TOUT   = CLK_HZ / 50;
  localparam int T7     = CLK_HZ * 100 / 44000;
  localparam int S7     = T7 / 32;

  int freq [10] = '{22000, 24694, 26163, 29366, 32963, 34923, 39200, 44000, 49388, 52325};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       audio_in = 1'b0;
  logic [9:0] keynote = '0;
  logic [4:0] p;
  logic       p_valid, signal_ok;

  pitch_meter #(.CLK_HZ(CLK_HZ)) dut (
    .clk       (clk),
    .rst       (rst),
    .audio_in  (audio_in),
    .keynote   (keynote),
    .p         (p),
    .p_valid   (p_valid),
    .signal_ok (signal_ok)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int got_q[$];
  int exp_q[$];
  always @(negedge clk) if (p_valid) got_q.push_back(int'(p));

  int n_chk = 0, n_pass = 0, n_fail = 0;
  bit synced = 1'b0, pushed = 1'b0;
  int last_acc = 0, cur_note = -1, last_p = 31, avg_sum = 0, avg_n = 0;

  task automatic check(string tag, int got, int exp);
    n_chk++;
    assert (got === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int grade(int idx, int meas);
    int t, s, k;
    t = CLK_HZ * 100 / freq[idx];
    s = t / 32;
    if (meas < t) begin
      k = (t - meas) / s;
      return 7 + ((k > 12) ? 12 : k);
    end
    k = (meas - t) / s;
    return 7 - ((k > 7) ? 7 : k);
  endfunction

  task automatic push(int v);
    exp_q.push_back(v);
    last_p = v;
    pushed = 1'b1;
  endtask

  task automatic rise();
    int gap;
    audio_in = 1'b1;
    pushed = 1'b0;
    gap = cyc - last_acc;
    if (gap >= MIN_P) begin
      last_acc = cyc;
      if (cur_note >= 0) begin
        if (!synced) begin
          synced = 1'b1;
          avg_sum = 0;
          avg_n = 0;
        end else begin
`ifdef PITCH_AVG4_EN
          avg_sum += gap;
          avg_n++;
          if (avg_n == 4) begin
            push(grade(cur_note, avg_sum / 4));
            avg_sum = 0;
            avg_n = 0;
          end
`else
          push(grade(cur_note, gap));
`endif
        end
      end
    end
  endtask

  task automatic square(int n);
    rise();
    tick(n / 2);
    audio_in = 1'b0;
    tick(n - n / 2);
  endtask

  // Short low blip inside the high phase; the total period stays n.
  task automatic square_glitch(int n);
    rise();
    tick(40);
    audio_in = 1'b0;
    tick(10);
    rise();
    tick(n / 2 - 50);
    audio_in = 1'b0;
    tick(n - n / 2);
  endtask

  task automatic set_note(logic [9:0] kn);
    int idx;
    idx = -1;
    keynote = kn;
    for (int i = 9; i >= 0; i--) if (kn[i]) idx = i;
    if (idx < 0 && cur_note >= 0) push(31);
    if (idx != cur_note) synced = 1'b0;
    cur_note = idx;
  endtask

  task automatic idle(int w);
    tick(w);
    if (synced && (cyc - last_acc) > TOUT + 20) begin
      push(31);
      synced = 1'b0;
    end
  endtask

  task automatic drain(string tag);
    int g;
    tick(30);
    while (exp_q.size() > 0) begin
      g = (got_q.size() > 0) ? got_q.pop_front() : -1;
      check(tag, g, exp_q.pop_front());
    end
    check({tag, "_extra"}, got_q.size(), 0);
    check({tag, "_p"}, int'(p), last_p);
  endtask

  int idx, t;
  logic [9:0] kn;

  initial begin
    set_note(10'b0010000000);
    tick(5);
    check("rst_p", int'(p), 31);
    check("rst_pv", int'(p_valid), 0);
    check("rst_ok", int'(signal_ok), 0);
    rst = 1'b0;
    last_acc = cyc;

    // In tune: first edge too early, second syncs, third is graded.
    tick(20);
    repeat (3) square(T7);
    drain("t1");
    check("t1_ok", int'(signal_ok), 1);

    // Sharp/flat steps, truncation and both clamps.
    square(T7 - 3 * S7);
    square(T7 + 2 * S7 + 15);
    square(T7 - 12 * S7 - 100);
    square(T7 + 8 * S7 + 50);
    square(T7);
    drain("t2");

    // Random notes (with higher keynote bits set too) and random periods.
    for (int r = 0; r < 2; r++) begin
      idx = $urandom_range(2, 9);
      kn = 10'(1 << idx) | (10'($urandom) & ~10'((2 << idx) - 1));
      set_note(kn);
      t = CLK_HZ * 100 / freq[idx];
      for (int j = 0; j < 6; j++) square(t / 2 + int'($urandom_range(0, t)));
      drain("rand");
    end

    // Loss of signal, then recovery.
    idle(TOUT + 500);
    drain("t4");
    check("t4_ok", int'(signal_ok), 0);
    set_note(10'b0010000000);
    repeat (3) square(T7);
    drain("t4b");
    check("t4b_ok", int'(signal_ok), 1);

    // Glitches are ignored; dropping the note reports no-note.
    repeat (3) square_glitch(T7);
    drain("t5");
    set_note(10'b0);
    drain("t5_none");

    // Reset while a result is being graded.
    set_note(10'b0010000000);
    square(T7);
    square(T7);
    square(T7 - 12 * S7 - 100);
    rise();
    tick(6);
    rst = 1'b1;
    tick(1);
    check("t5_rst_p", int'(p), 31);
    check("t5_rst_pv", int'(p_valid), 0);
    check("t5_rst_ok", int'(signal_ok), 0);
    audio_in = 1'b0;
    if (pushed) void'(exp_q.pop_back());
    rst = 1'b0;
    last_acc = cyc;
    synced = 1'b0;
    cur_note = -1;
    last_p = 31;
    drain("t5_rst");

    set_note(10'b0010000000);
    repeat (6) square(T7 + int'($urandom_range(0, 200)));
    drain("t6");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
